// File: rtl/steer_pkg.sv
// Shared helpers for the one-to-N steering buffer: select legality and
// saturating counter increment.
package steer_pkg;

    localparam int MAX_N = 64;
    localparam int MAX_CNT_W = 64;

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [MAX_N-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_N; i++) begin
            cnt += int'(v[i]);
        end
        return (cnt == 1);
    endfunction

    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                     input int unsigned w);
        logic [MAX_CNT_W-1:0] top;
        top = (w >= MAX_CNT_W) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/steer_slot.sv
// Single-entry holding register for one output channel; it can drain and
// reload in the same cycle so a steady stream sees no bubbles.
module steer_slot #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    input  logic         i_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_d,
    output logic         o_cap
);

    logic         vld_p1;
    logic [W-1:0] data_p1;

    // Stage p1: held beat, valid until the consumer takes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
        end else if (i_load) begin
            vld_p1 <= 1'b1;
        end else if (vld_p1 && i_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            data_p1 <= i_d;
        end
    end

    assign o_vld = vld_p1;
    assign o_d   = data_p1;
    assign o_cap = ~vld_p1 | i_rdy;

endmodule

// File: rtl/steer.sv
// One-to-N steering buffer: each input beat goes to the channel named by a
// one-hot select; beats with an illegal select are consumed and counted.
module steer
    import steer_pkg::*;
#(
    parameter int W     = 32,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_x_vld,
    input  logic [W-1:0]     i_x,
    input  logic [N-1:0]     i_sel,
    output logic             o_x_rdy,
    output logic [N-1:0]     o_y_vld,
    output logic [N*W-1:0]   o_y,
    input  logic [N-1:0]     i_y_rdy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_drop_cnt
);

    logic             legal;
    logic             fire;
    logic [N-1:0]     cap;
    logic [N-1:0]     load;
    logic             err_p1;
    logic [CNT_W-1:0] cnt_p1;

    assign legal   = is_onehot(MAX_N'(i_sel));
    // Illegal selects never stall the producer; they are swallowed here.
    assign o_x_rdy = legal ? |(i_sel & cap) : 1'b1;
    assign fire    = i_x_vld & o_x_rdy;
    assign load    = (fire && legal) ? i_sel : '0;

    for (genvar i = 0; i < N; i++) begin : g_slot
        steer_slot #(.W(W)) u_slot (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_load (load[i]),
            .i_d    (i_x),
            .i_rdy  (i_y_rdy[i]),
            .o_vld  (o_y_vld[i]),
            .o_d    (o_y[W*i +: W]),
            .o_cap  (cap[i])
        );
    end

    // Stage p1: drop pulse and saturating drop count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            err_p1 <= fire & ~legal;
            if (fire && !legal) begin
                cnt_p1 <= CNT_W'(sat_inc(MAX_CNT_W'(cnt_p1), CNT_W));
            end
        end
    end

    assign o_err      = err_p1;
    assign o_drop_cnt = cnt_p1;

endmodule

// File: tb/tb_steer.sv
// Directed self-checking bench for steer; a second instance with a 2-bit
// drop counter shares the stimulus to exercise saturation.
module tb_steer;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           x_vld;
    logic [W-1:0]   x;
    logic [N-1:0]   sel;
    logic           x_rdy;
    logic [N-1:0]   y_vld;
    logic [N*W-1:0] y;
    logic [N-1:0]   y_rdy;
    logic           err;
    logic [15:0]    drop_cnt;

    logic           x_rdy2;
    logic [N-1:0]   y_vld2;
    logic [N*W-1:0] y2;
    logic           err2;
    logic [1:0]     drop_cnt2;

    int total = 0;
    int bad   = 0;

    steer #(.W(W), .N(N), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_x_vld(x_vld), .i_x(x), .i_sel(sel),
        .o_x_rdy(x_rdy), .o_y_vld(y_vld), .o_y(y), .i_y_rdy(y_rdy),
        .o_err(err), .o_drop_cnt(drop_cnt)
    );

    steer #(.W(W), .N(N), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_x_vld(x_vld), .i_x(x), .i_sel(sel),
        .o_x_rdy(x_rdy2), .o_y_vld(y_vld2), .o_y(y2), .i_y_rdy(y_rdy),
        .o_err(err2), .o_drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; x_vld = 1'b0; x = '0; sel = '0; y_rdy = '0;
        step();
        step();
        rst = 1'b0;
        settle();
        check("rst_vld", 64'(y_vld), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_cnt", 64'(drop_cnt), 64'h0);

        // 1. basic steer to channel 2
        y_rdy = 4'b1111; x = 32'hA5A5_0001; sel = 4'b0100; x_vld = 1'b1;
        settle();
        check("t1_rdy", 64'(x_rdy), 64'h1);
        step();
        x_vld = 1'b0;
        settle();
        check("t1_vld", 64'(y_vld), 64'h4);
        check("t1_data", 64'(y[W*2 +: W]), 64'hA5A5_0001);
        step();
        check("t1_drain", 64'(y_vld), 64'h0);

        // 2. channel 1 blocked, channel 3 still flows
        y_rdy = 4'b1101; x = 32'h1111_1111; sel = 4'b0010; x_vld = 1'b1;
        settle();
        check("t2_rdy_first", 64'(x_rdy), 64'h1);
        step();
        x = 32'h2222_2222;
        settle();
        check("t2_rdy_blocked", 64'(x_rdy), 64'h0);
        step();
        check("t2_hold_vld", 64'(y_vld), 64'h2);
        check("t2_hold_data", 64'(y[W*1 +: W]), 64'h1111_1111);
        x = 32'h3333_3333; sel = 4'b1000;
        settle();
        check("t2_rdy_other", 64'(x_rdy), 64'h1);
        step();
        x_vld = 1'b0;
        settle();
        check("t2_vld_both", 64'(y_vld), 64'hA);
        check("t2_ch3", 64'(y[W*3 +: W]), 64'h3333_3333);
        check("t2_ch1", 64'(y[W*1 +: W]), 64'h1111_1111);
        step();
        check("t2_ch3_drain", 64'(y_vld), 64'h2);
        y_rdy = 4'b1111;
        step();
        check("t2_ch1_drain", 64'(y_vld), 64'h0);

        // 3. back-to-back streaming on channel 0
        for (int i = 0; i < 8; i++) begin
            x = 32'(i); sel = 4'b0001; x_vld = 1'b1;
            settle();
            check("t3_rdy", 64'(x_rdy), 64'h1);
            step();
            check("t3_vld", 64'(y_vld), 64'h1);
            check("t3_data", 64'(y[W*0 +: W]), 64'(i));
        end
        x_vld = 1'b0;
        step();
        check("t3_empty", 64'(y_vld), 64'h0);

        // 4. illegal selects are consumed and counted
        x = 32'hDEAD_BEEF; sel = 4'b0000; x_vld = 1'b1;
        settle();
        check("t4_rdy_zero", 64'(x_rdy), 64'h1);
        step();
        check("t4_err1", 64'(err), 64'h1);
        check("t4_cnt1", 64'(drop_cnt), 64'h1);
        check("t4_vld1", 64'(y_vld), 64'h0);
        sel = 4'b0110;
        settle();
        check("t4_rdy_multi", 64'(x_rdy), 64'h1);
        step();
        x_vld = 1'b0;
        settle();
        check("t4_err2", 64'(err), 64'h1);
        check("t4_cnt2", 64'(drop_cnt), 64'h2);
        check("t4_vld2", 64'(y_vld), 64'h0);
        step();
        check("t4_err_low", 64'(err), 64'h0);
        check("t4_cnt_hold", 64'(drop_cnt), 64'h2);
        check("t4_cnt2b_two", 64'(drop_cnt2), 64'h2);
        sel = 4'b1111; x_vld = 1'b1;
        step();
        step();
        step();
        x_vld = 1'b0;
        step();
        check("t4_cnt_five", 64'(drop_cnt), 64'h5);
        check("t4_sat", 64'(drop_cnt2), 64'h3);
        check("t4_vld_none", 64'(y_vld), 64'h0);

        // 5. drain and reload slot 0 in the same cycle
        y_rdy = 4'b0000; x = 32'h0000_AAAA; sel = 4'b0001; x_vld = 1'b1;
        step();
        x = 32'h0000_1234; y_rdy = 4'b0001;
        settle();
        check("t5_rdy", 64'(x_rdy), 64'h1);
        step();
        x_vld = 1'b0;
        settle();
        check("t5_vld", 64'(y_vld), 64'h1);
        check("t5_data", 64'(y[W*0 +: W]), 64'h0000_1234);
        step();
        check("t5_drain", 64'(y_vld), 64'h0);

        // 6. reset mid-operation, with an illegal beat firing during reset
        y_rdy = 4'b0000; x = 32'h0000_0001; sel = 4'b0001; x_vld = 1'b1;
        step();
        x = 32'h0000_0002; sel = 4'b1000;
        step();
        x_vld = 1'b0;
        settle();
        check("t6_full", 64'(y_vld), 64'h9);
        sel = 4'b0000; x_vld = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; x_vld = 1'b0;
        settle();
        check("t6_vld", 64'(y_vld), 64'h0);
        check("t6_err", 64'(err), 64'h0);
        check("t6_cnt", 64'(drop_cnt), 64'h0);
        y_rdy = 4'b1111; x = 32'hCAFE_F00D; sel = 4'b0010; x_vld = 1'b1;
        step();
        x_vld = 1'b0;
        settle();
        check("t6_post_vld", 64'(y_vld), 64'h2);
        check("t6_post_data", 64'(y[W*1 +: W]), 64'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/steer.md
Name: steer

Overview:
- One-to-N steering buffer: accepts one W-bit valid/ready stream and delivers each beat to exactly one of N output channels, chosen by a one-hot destination vector.
- Acts as the distribution-side counterpart of the one-hot N-to-1 selector. It sits where a single producer fans out to N consumers, such as per-lane queues.
- Each output channel has a single-entry registered holding slot. A beat steered to a blocked channel does not stall beats bound for other channels.

Parameters:
- W, 32, data width of each beat.
- N, 4, number of output channels (N >= 2).
- CNT_W, 16, width of the saturating illegal-select drop counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_x_vld  input  1  input beat valid.
- i_x  input  W  input beat data.
- i_sel  input  N  one-hot destination select; must be stable while i_x_vld=1 and o_x_rdy=0.
- o_x_rdy  output  1  input ready.
- o_y_vld  output  N  per-channel output valid, bit i for channel i.
- o_y  output  N*W  per-channel output data, flattened; channel i occupies o_y[W*i +: W].
- i_y_rdy  input  N  per-channel consumer ready.
- o_err  output  1  one-cycle pulse: a beat with illegal i_sel was dropped.
- o_drop_cnt  output  CNT_W  saturating count of dropped beats.

Behaviour:
- Clocking and reset:
  - One clock, i_clk. Reset is synchronous and active-high on i_rst.
  - Reset clears every slot valid, o_err and o_drop_cnt to 0. Slot data is not reset; o_y is don't-care while its valid is 0.
- Legality: legal = i_sel is exactly one-hot (popcount == 1). Zero or multi-hot is illegal.
- Channel capacity: per channel, cap[i] = ~vld_q[i] | i_y_rdy[i]. A slot can take a new beat in the same cycle it drains.
- Ready:
  - o_x_rdy = legal ? |(i_sel & cap) : 1'b1.
  - Illegal beats are always consumed. o_x_rdy has a combinational path from i_sel and i_y_rdy; it never depends on i_x_vld.
- Accept: fire = i_x_vld & o_x_rdy.
  - If fire and legal, slot k (i_sel[k]=1) loads i_x and sets vld_q[k] in the next cycle.
  - Latency is 1 cycle from accept to o_y_vld[k].
- Drain: o_y_vld[i] = vld_q[i]; o_y slice i = data_q[i].
  - When vld_q[i] & i_y_rdy[i], the slot clears next cycle, unless it is reloaded in the same cycle, in which case it stays valid with the new data.
- Independence: channels drain independently and concurrently; up to N beats may be presented simultaneously.
- Illegal beat:
  - If fire and not legal, no slot changes.
  - o_err=1 next cycle, for exactly one cycle per dropped beat.
  - o_drop_cnt increments by 1 and saturates at all-ones.
- Ordering: beats to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Output stability: once o_y_vld[i]=1, o_y slice i holds until consumed.
- Reset mid-operation: all pending slot contents are discarded. No spurious o_err occurs in the cycle after reset.

Decomposition:
- Shared package:
  - popcount/one-hot legality helper function.
  - saturating-increment helper.
- Natural sub-module: steer_slot, a single-entry holding register with vld/rdy and load/drain, instantiated N times in a generate loop. The top level holds the legality check, ready formation and drop counter.

Test Plan:
1. Basic steer: W=32, N=4. Send 0xA5A5_0001 with i_sel=4'b0100 and all i_y_rdy=1 -> next cycle o_y_vld=4'b0100, channel-2 slice = 0xA5A5_0001, drained one cycle later.
2. Blocked channel isolation: i_y_rdy[1]=0 and slot 1 full. A beat to sel=4'b0010 gives o_x_rdy=0 and holds. Switching to a beat for sel=4'b1000 gives o_x_rdy=1 and is delivered on channel 3 while channel 1 data is unchanged.
3. Full-throughput same-channel streaming: 8 back-to-back beats 0..7 to sel=4'b0001 with i_y_rdy[0]=1 -> o_x_rdy stays 1 every cycle and channel 0 emits 0..7 in order with no gaps.
4. Illegal select: a beat with sel=4'b0000, then one with sel=4'b0110 -> both accepted (o_x_rdy=1), no o_y_vld change, o_err pulses twice and o_drop_cnt = 2. With CNT_W=2, five drops leave the counter saturated at 3.
5. Simultaneous drain/load: slot 0 full, i_y_rdy[0]=1, new beat 0x1234 to sel=4'b0001 -> accepted, o_y_vld[0] stays 1 and channel-0 data becomes 0x1234 the next cycle.
6. Reset mid-operation: fill slots 0 and 3, assert i_rst for 1 cycle -> o_y_vld=0, o_err=0 and o_drop_cnt=0 the next cycle; the first post-reset beat is delivered normally.
